// File: rtl/acc_bank_ctrl_nn.sv
// Double-buffered accumulator bank controller.
// One bank accumulates saturating MAC lane results while the other is drained
// entry by entry over a valid/ready port; swapping banks is deferred while a
// drain is in progress.
module acc_bank_ctrl_nn #(
  parameter int N_MACS  = 4,
  parameter int IN_W    = 16,
  parameter int ACC_W   = 24,
  parameter int N_TILES = 4
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [11:0]               valid_ctrl,
  input  logic [2:0]                acc_sel_tile,
  input  logic [N_MACS*IN_W-1:0]    mac_in,
  input  logic                      clear,
  output logic [N_MACS*ACC_W-1:0]   acc_out,
  output logic                      acc_out_valid,
  input  logic                      acc_out_ready,
  output logic                      acc_out_last,
  output logic                      busy,
  output logic                      ovf,
  output logic                      err
);

  localparam int unsigned NT   = N_TILES;
  localparam int unsigned NM   = N_MACS;
  localparam int unsigned HALF = N_MACS / 2;
  localparam logic [2:0]  LAST_IDX = 3'(N_TILES - 1);
  localparam logic [ACC_W-1:0] ACC_MAX = {1'b0, {(ACC_W-1){1'b1}}};
  localparam logic [ACC_W-1:0] ACC_MIN = {1'b1, {(ACC_W-1){1'b0}}};

  typedef enum logic {IDLE, DRAIN} state_t;

  state_t state, state_nx;
  logic   bank_sel, bank_sel_nx;
  logic   swap_pending, swap_pending_nx;
  logic   [2:0] rd_idx, rd_idx_nx;
  logic   rd_bank;

  logic [ACC_W-1:0] bank [2][N_TILES][N_MACS];

  logic acc_lo, acc_hi, drain_start, swap_req;
  logic tile_ok, wr_any, wr_go, bad_sel, hs, swap_any;
  logic [N_MACS-1:0]  lane_en;
  logic [N_MACS-1:0]  lane_ovf;
  logic [N_TILES-1:0] tile_hit;
  logic [N_TILES-1:0] rd_hit;
  logic [IN_W-1:0]    lane_in [N_MACS];
  logic [ACC_W-1:0]   wr_cur  [N_MACS];
  logic [ACC_W:0]     sum_ext [N_MACS];
  logic [ACC_W-1:0]   lane_sum[N_MACS];

  logic unused_ctrl;
  assign unused_ctrl = ^{valid_ctrl[11:8], valid_ctrl[5:4], valid_ctrl[2:1]};

  assign acc_lo      = valid_ctrl[0];
  assign acc_hi      = valid_ctrl[3];
  assign drain_start = valid_ctrl[6];
  assign swap_req    = valid_ctrl[7];
  assign rd_bank     = ~bank_sel;

  assign tile_ok = ({29'd0, acc_sel_tile} < NT);
  assign wr_any  = acc_lo | acc_hi;
  assign wr_go   = wr_any & tile_ok & ~clear;
  assign bad_sel = wr_any & ~tile_ok;
  assign hs      = acc_out_valid & acc_out_ready;

  assign acc_out_valid = (state == DRAIN);
  assign acc_out_last  = (state == DRAIN) && (rd_idx == LAST_IDX);

  // Decode target/read entry and compute saturating per-lane sums for the write entry
  always_comb begin
    tile_hit = '0;
    rd_hit   = '0;
    lane_en  = '0;
    lane_ovf = '0;
    for (int unsigned t = 0; t < NT; t++) begin
      tile_hit[t] = ({29'd0, acc_sel_tile} == t);
      rd_hit[t]   = ({29'd0, rd_idx} == t);
    end
    for (int unsigned k = 0; k < NM; k++) begin
      lane_en[k] = (k < HALF) ? acc_lo : acc_hi;
      lane_in[k] = mac_in[k*IN_W +: IN_W];
      wr_cur[k]  = '0;
      for (int unsigned t = 0; t < NT; t++) begin
        if (tile_hit[t]) wr_cur[k] = bank[bank_sel][t][k];
      end
      sum_ext[k]  = {wr_cur[k][ACC_W-1], wr_cur[k]}
                  + {{(ACC_W+1-IN_W){lane_in[k][IN_W-1]}}, lane_in[k]};
      lane_ovf[k] = sum_ext[k][ACC_W] ^ sum_ext[k][ACC_W-1];
      lane_sum[k] = lane_ovf[k] ? (sum_ext[k][ACC_W] ? ACC_MIN : ACC_MAX)
                                : sum_ext[k][ACC_W-1:0];
    end
  end

  // Present the current read-bank entry while draining, zero otherwise
  always_comb begin
    acc_out = '0;
    if (state == DRAIN) begin
      for (int unsigned t = 0; t < NT; t++) begin
        if (rd_hit[t]) begin
          for (int unsigned k = 0; k < NM; k++) begin
            acc_out[k*ACC_W +: ACC_W] = bank[rd_bank][t][k];
          end
        end
      end
    end
  end

  // Drain FSM next state, read index, bank select and deferred swap
  always_comb begin
    state_nx        = state;
    rd_idx_nx       = rd_idx;
    bank_sel_nx     = bank_sel;
    swap_pending_nx = swap_pending;
    swap_any        = swap_pending | swap_req;
    case (state)
      IDLE: begin
        if (swap_req) bank_sel_nx = ~bank_sel;
        if (drain_start) begin
          state_nx  = DRAIN;
          rd_idx_nx = '0;
        end
      end
      DRAIN: begin
        swap_pending_nx = swap_any;
        if (hs) begin
          if (rd_idx == LAST_IDX) begin
            // A swap requested on the final handshake cycle is applied now too
            state_nx        = IDLE;
            rd_idx_nx       = '0;
            swap_pending_nx = 1'b0;
            if (swap_any) bank_sel_nx = ~bank_sel;
          end else begin
            rd_idx_nx = rd_idx + 3'd1;
          end
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  // Control state registers; busy is registered from the next-state values
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= IDLE;
      rd_idx       <= '0;
      bank_sel     <= 1'b0;
      swap_pending <= 1'b0;
      busy         <= 1'b0;
    end else begin
      state        <= state_nx;
      rd_idx       <= rd_idx_nx;
      bank_sel     <= bank_sel_nx;
      swap_pending <= swap_pending_nx;
      busy         <= (state_nx == DRAIN) | swap_pending_nx;
    end
  end

  // Bank storage: clear/accumulate on the write bank, zero-on-read for the read bank
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned b = 0; b < 2; b++)
        for (int unsigned t = 0; t < NT; t++)
          for (int unsigned k = 0; k < NM; k++)
            bank[b][t][k] <= '0;
    end else begin
      for (int unsigned t = 0; t < NT; t++) begin
        for (int unsigned k = 0; k < NM; k++) begin
          if (clear)
            bank[bank_sel][t][k] <= '0;
          else if (wr_go && tile_hit[t] && lane_en[k])
            bank[bank_sel][t][k] <= lane_sum[k];
          if (hs && rd_hit[t])
            bank[rd_bank][t][k] <= '0;
        end
      end
    end
  end

  // Sticky saturation and bad-index flags, dropped only by clear
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ovf <= 1'b0;
      err <= 1'b0;
    end else if (clear) begin
      ovf <= 1'b0;
      err <= 1'b0;
    end else begin
      ovf <= ovf | (wr_go & |(lane_ovf & lane_en));
      err <= err | bad_sel;
    end
  end

endmodule

// File: tb/tb_acc_bank_ctrl_nn.sv
// Directed self-checking bench for acc_bank_ctrl_nn with default parameters.
module tb_acc_bank_ctrl_nn;

  localparam int N_MACS  = 4;
  localparam int IN_W    = 16;
  localparam int ACC_W   = 24;
  localparam int N_TILES = 4;
  localparam int OW      = N_MACS * ACC_W;

  logic                    clk = 1'b0;
  logic                    rst_n;
  logic [11:0]             valid_ctrl;
  logic [2:0]              acc_sel_tile;
  logic [N_MACS*IN_W-1:0]  mac_in;
  logic                    clear;
  logic [OW-1:0]           acc_out;
  logic                    acc_out_valid;
  logic                    acc_out_ready;
  logic                    acc_out_last;
  logic                    busy;
  logic                    ovf;
  logic                    err;

  int tests = 0;
  int fails = 0;

  acc_bank_ctrl_nn #(
    .N_MACS (N_MACS),
    .IN_W   (IN_W),
    .ACC_W  (ACC_W),
    .N_TILES(N_TILES)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .valid_ctrl   (valid_ctrl),
    .acc_sel_tile (acc_sel_tile),
    .mac_in       (mac_in),
    .clear        (clear),
    .acc_out      (acc_out),
    .acc_out_valid(acc_out_valid),
    .acc_out_ready(acc_out_ready),
    .acc_out_last (acc_out_last),
    .busy         (busy),
    .ovf          (ovf),
    .err          (err)
  );

  always #5 clk = ~clk;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic drive_idle;
    valid_ctrl    = '0;
    acc_sel_tile  = '0;
    mac_in        = '0;
    clear         = 1'b0;
    acc_out_ready = 1'b1;
  endtask

  function automatic logic [N_MACS*IN_W-1:0] mac4(input logic [15:0] l0, l1, l2, l3);
    return {l3, l2, l1, l0};
  endfunction

  function automatic logic [OW-1:0] lanes4(input logic [23:0] l0, l1, l2, l3);
    return {l3, l2, l1, l0};
  endfunction

  function automatic logic [OW-1:0] exp_bp(input int t);
    return lanes4(24'(t*4+1), 24'(t*4+2), 24'(t*4+3),
                  (t == 1) ? 24'hFFFFF9 : 24'(t*4+4));
  endfunction

  task automatic test_reset;
    rst_n = 1'b0;
    drive_idle();
    repeat (2) @(posedge clk);
    #1;
    tests++;
    if ({acc_out_valid, acc_out_last, busy, ovf, err} !== 5'b0) begin
      fails++;
      $display("FAIL reset_flags: got %b expected 00000",
               {acc_out_valid, acc_out_last, busy, ovf, err});
    end
    tests++;
    if (acc_out !== '0) begin
      fails++;
      $display("FAIL reset_acc_out: got %h expected 0", acc_out);
    end
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_accumulate;
    logic [OW-1:0] exp;
    acc_sel_tile = 3'd2;
    mac_in       = mac4(16'd5, 16'd5, 16'd5, 16'd5);
    valid_ctrl   = 12'h009;
    repeat (3) tick();
    mac_in     = '0;
    valid_ctrl = 12'h080;
    tick();
    valid_ctrl = 12'h040;
    tick();
    valid_ctrl = '0;
    for (int i = 0; i < N_TILES; i++) begin
      exp = (i == 2) ? {4{24'd15}} : '0;
      tests++;
      if (acc_out !== exp) begin
        fails++;
        $display("FAIL accum_entry%0d: got %h expected %h", i, acc_out, exp);
      end
      tests++;
      if ({acc_out_valid, acc_out_last, busy} !== {1'b1, (i == N_TILES-1), 1'b1}) begin
        fails++;
        $display("FAIL accum_ctl%0d: valid/last/busy got %b expected %b", i,
                 {acc_out_valid, acc_out_last, busy}, {1'b1, (i == N_TILES-1), 1'b1});
      end
      tick();
    end
    tests++;
    if ({acc_out_valid, busy} !== 2'b00) begin
      fails++;
      $display("FAIL accum_end: valid/busy got %b expected 00", {acc_out_valid, busy});
    end
  endtask

  task automatic test_saturation;
    logic [OW-1:0] exp;
    acc_sel_tile = 3'd0;
    valid_ctrl   = 12'h001;
    mac_in       = mac4(16'h7FFF, 16'h8000, 16'd0, 16'd0);
    repeat (256) tick();
    mac_in = mac4(16'd248, 16'd0, 16'd0, 16'd0);
    tick();
    tests++;
    if (ovf !== 1'b0) begin
      fails++;
      $display("FAIL sat_no_ovf_yet: ovf got %b expected 0", ovf);
    end
    mac_in = mac4(16'd100, 16'hFFFF, 16'd0, 16'd0);
    tick();
    tests++;
    if (ovf !== 1'b1) begin
      fails++;
      $display("FAIL sat_ovf_set: ovf got %b expected 1", ovf);
    end
    mac_in     = '0;
    valid_ctrl = 12'h080;
    tick();
    valid_ctrl = 12'h040;
    tick();
    valid_ctrl = '0;
    for (int i = 0; i < N_TILES; i++) begin
      exp = (i == 0) ? lanes4(24'h7FFFFF, 24'h800000, 24'd0, 24'd0) : '0;
      tests++;
      if (acc_out !== exp) begin
        fails++;
        $display("FAIL sat_entry%0d: got %h expected %h", i, acc_out, exp);
      end
      tick();
    end
    tests++;
    if (ovf !== 1'b1) begin
      fails++;
      $display("FAIL sat_ovf_sticky: ovf got %b expected 1", ovf);
    end
    clear = 1'b1;
    tick();
    clear = 1'b0;
    tests++;
    if (ovf !== 1'b0) begin
      fails++;
      $display("FAIL sat_ovf_clear: ovf got %b expected 0", ovf);
    end
  endtask

  task automatic test_backpressure;
    for (int t = 0; t < N_TILES; t++) begin
      acc_sel_tile = 3'(t);
      mac_in = mac4(16'(t*4+1), 16'(t*4+2), 16'(t*4+3), (t == 1) ? 16'hFFF9 : 16'(t*4+4));
      valid_ctrl = 12'h009;
      tick();
    end
    mac_in        = '0;
    valid_ctrl    = 12'h080;
    tick();
    acc_out_ready = 1'b0;
    valid_ctrl    = 12'h040;
    tick();
    valid_ctrl = '0;
    for (int c = 0; c < 5; c++) begin
      tests++;
      if ({acc_out_valid, acc_out_last} !== 2'b10 || acc_out !== exp_bp(0)) begin
        fails++;
        $display("FAIL bp_hold%0d: valid/last %b data %h expected 10 data %h", c,
                 {acc_out_valid, acc_out_last}, acc_out, exp_bp(0));
      end
      tick();
    end
    acc_out_ready = 1'b1;
    for (int t = 0; t < N_TILES; t++) begin
      tests++;
      if (acc_out !== exp_bp(t) || acc_out_last !== (t == N_TILES-1) || acc_out_valid !== 1'b1) begin
        fails++;
        $display("FAIL bp_entry%0d: data %h last %b valid %b expected data %h last %b valid 1",
                 t, acc_out, acc_out_last, acc_out_valid, exp_bp(t), (t == N_TILES-1));
      end
      tick();
    end
    tests++;
    if (acc_out_valid !== 1'b0) begin
      fails++;
      $display("FAIL bp_done: valid got %b expected 0", acc_out_valid);
    end
    valid_ctrl = 12'h040;
    tick();
    valid_ctrl = '0;
    for (int t = 0; t < N_TILES; t++) begin
      tests++;
      if (acc_out !== '0 || acc_out_valid !== 1'b1) begin
        fails++;
        $display("FAIL bp_zeroed%0d: data %h valid %b expected 0 valid 1", t, acc_out, acc_out_valid);
      end
      tick();
    end
  endtask

  task automatic test_swap_during_drain;
    tests++;
    if (dut.bank_sel !== 1'b1) begin
      fails++;
      $display("FAIL swap_pre: bank_sel got %b expected 1", dut.bank_sel);
    end
    valid_ctrl = 12'h040;
    tick();
    valid_ctrl = '0;
    tick();
    valid_ctrl = 12'h080;
    tick();
    valid_ctrl = 12'h0C0;
    tests++;
    if ({busy, dut.bank_sel, acc_out_valid} !== 3'b111) begin
      fails++;
      $display("FAIL swap_pending_e2: busy/bank_sel/valid got %b expected 111",
               {busy, dut.bank_sel, acc_out_valid});
    end
    tick();
    valid_ctrl = '0;
    tests++;
    if ({busy, dut.bank_sel, acc_out_last} !== 3'b111) begin
      fails++;
      $display("FAIL swap_pending_e3: busy/bank_sel/last got %b expected 111",
               {busy, dut.bank_sel, acc_out_last});
    end
    tick();
    tests++;
    if ({busy, dut.bank_sel, acc_out_valid} !== 3'b000) begin
      fails++;
      $display("FAIL swap_applied: busy/bank_sel/valid got %b expected 000",
               {busy, dut.bank_sel, acc_out_valid});
    end
    repeat (3) tick();
    tests++;
    if ({busy, dut.bank_sel, acc_out_valid} !== 3'b000) begin
      fails++;
      $display("FAIL swap_once: busy/bank_sel/valid got %b expected 000",
               {busy, dut.bank_sel, acc_out_valid});
    end
  endtask

  task automatic test_boundaries;
    acc_sel_tile = 3'd1;
    mac_in       = mac4(16'd4, 16'd4, 16'd4, 16'd4);
    valid_ctrl   = 12'h009;
    tick();
    acc_sel_tile = 3'd5;
    mac_in       = mac4(16'd9, 16'd9, 16'd9, 16'd9);
    valid_ctrl   = 12'h001;
    tick();
    valid_ctrl = '0;
    tick();
    tests++;
    if ({err, ovf} !== 2'b10) begin
      fails++;
      $display("FAIL bound_err: err/ovf got %b expected 10", {err, ovf});
    end
    acc_sel_tile = 3'd0;
    mac_in       = mac4(16'd3, 16'd3, 16'd3, 16'd3);
    valid_ctrl   = 12'h009;
    clear        = 1'b1;
    tick();
    clear      = 1'b0;
    mac_in     = '0;
    tests++;
    if ({err, ovf} !== 2'b00) begin
      fails++;
      $display("FAIL bound_clear_flags: err/ovf got %b expected 00", {err, ovf});
    end
    valid_ctrl = 12'h080;
    tick();
    valid_ctrl = 12'h040;
    tick();
    valid_ctrl = '0;
    for (int t = 0; t < N_TILES; t++) begin
      tests++;
      if (acc_out !== '0) begin
        fails++;
        $display("FAIL bound_entry%0d: got %h expected 0", t, acc_out);
      end
      tick();
    end
  endtask

  task automatic test_reset_mid_drain;
    logic any_nz;
    for (int t = 0; t < N_TILES; t++) begin
      acc_sel_tile = 3'(t);
      mac_in       = mac4(16'd7, 16'd7, 16'd7, 16'd7);
      valid_ctrl   = 12'h009;
      tick();
    end
    valid_ctrl = 12'h080;
    tick();
    valid_ctrl = 12'h040;
    tick();
    acc_sel_tile = 3'd0;
    mac_in       = mac4(16'd3, 16'd3, 16'd3, 16'd3);
    valid_ctrl   = 12'h009;
    tick();
    tick();
    valid_ctrl = '0;
    tests++;
    if (acc_out !== {4{24'd7}} || acc_out_valid !== 1'b1 || acc_out_last !== 1'b0) begin
      fails++;
      $display("FAIL rst_pre_entry2: data %h valid %b last %b expected %h valid 1 last 0",
               acc_out, acc_out_valid, acc_out_last, {4{24'd7}});
    end
    #2;
    rst_n = 1'b0;
    #1;
    tests++;
    if ({acc_out_valid, acc_out_last, busy, ovf, err} !== 5'b0 || acc_out !== '0) begin
      fails++;
      $display("FAIL rst_async_outputs: flags %b data %h expected 00000 data 0",
               {acc_out_valid, acc_out_last, busy, ovf, err}, acc_out);
    end
    any_nz = 1'b0;
    for (int b = 0; b < 2; b++)
      for (int t = 0; t < N_TILES; t++)
        for (int k = 0; k < N_MACS; k++)
          if (dut.bank[b][t][k] !== '0) any_nz = 1'b1;
    tests++;
    if (any_nz !== 1'b0 || dut.bank_sel !== 1'b0) begin
      fails++;
      $display("FAIL rst_async_state: nonzero_entry %b bank_sel %b expected 0 0", any_nz, dut.bank_sel);
    end
    tick();
    rst_n = 1'b1;
    tick();
    valid_ctrl = 12'h040;
    tick();
    valid_ctrl = '0;
    for (int t = 0; t < N_TILES; t++) begin
      tests++;
      if (acc_out !== '0 || acc_out_valid !== 1'b1) begin
        fails++;
        $display("FAIL rst_drain%0d: data %h valid %b expected 0 valid 1", t, acc_out, acc_out_valid);
      end
      tick();
    end
  endtask

  initial begin
    test_reset();
    test_accumulate();
    test_saturation();
    test_backpressure();
    test_swap_during_drain();
    test_boundaries();
    test_reset_mid_drain();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/acc_bank_ctrl_nn.md
ACC_BANK_CTRL_NN -- requirements
Module: acc_bank_ctrl_nn

Interface
REQ-001 SHALL have parameter N_MACS, default 4, the number of MAC lanes (even, >=2).
REQ-002 SHALL have parameter IN_W, default 16, the signed width of each MAC lane result.
REQ-003 SHALL have parameter ACC_W, default 24, the signed accumulator width (ACC_W > IN_W).
REQ-004 SHALL have parameter N_TILES, default 4, the accumulator entries per bank (<=8).
REQ-005 SHALL have one clock and an asynchronous, active-low reset, with ports clk and rst_n.
REQ-006 clk  input  1  rising-edge clock.
REQ-007 rst_n  input  1  asynchronous active-low reset.
REQ-008 valid_ctrl  input  12  pipeline control bus; bit0=acc lanes low half, bit3=acc lanes high half, bit6=start drain, bit7=swap banks, other bits ignored.
REQ-009 acc_sel_tile  input  3  target entry index for accumulation.
REQ-010 mac_in  input  N_MACS*IN_W  signed lane results, lane k at bits [k*IN_W +: IN_W].
REQ-011 clear  input  1  single-cycle pulse that zeroes the write bank.
REQ-012 acc_out  output  N_MACS*ACC_W  drained entry, same lane packing as mac_in.
REQ-013 acc_out_valid  output  1  acc_out holds a drained entry.
REQ-014 acc_out_ready  input  1  consumer accepts acc_out.
REQ-015 acc_out_last  output  1  qualifies the final entry of a drain.
REQ-016 busy  output  1  drain active or swap pending.
REQ-017 ovf  output  1  sticky saturation flag.
REQ-018 err  output  1  sticky flag for out-of-range acc_sel_tile.

Function
REQ-019 SHALL hold two banks A and B of N_TILES x N_MACS ACC_W-bit entries; bank_sel chooses the write bank, the other bank is the read bank.
REQ-020 valid_ctrl[0] high SHALL add mac_in lanes 0..N_MACS/2-1 (sign-extended) into write-bank entry acc_sel_tile at the next edge.
REQ-021 valid_ctrl[3] high SHALL do the same for lanes N_MACS/2..N_MACS-1; both bits high in one cycle update all lanes.
REQ-022 Accumulation SHALL saturate to the signed ACC_W range per lane; any saturation sets ovf.
REQ-023 acc_sel_tile >= N_TILES with valid_ctrl[0] or [3] high SHALL drop the write and set err.
REQ-024 clear SHALL zero every write-bank entry; clear and an accumulate in the same cycle -> clear wins, write dropped.
REQ-025 valid_ctrl[7] in IDLE SHALL toggle bank_sel at the next edge; an accumulate in that same cycle targets the pre-toggle write bank.
REQ-026 valid_ctrl[7] during DRAIN SHALL set swap_pending; the toggle occurs on the cycle the drain returns to IDLE, then swap_pending clears; further swaps while pending are absorbed.
REQ-027 Drain FSM states: IDLE, DRAIN. IDLE->DRAIN when valid_ctrl[6] high; DRAIN->IDLE on handshake of the entry with index N_TILES-1.
REQ-028 acc_out_valid SHALL rise the cycle after valid_ctrl[6] is sampled, presenting read-bank entry 0.
REQ-029 A handshake (acc_out_valid & acc_out_ready) SHALL zero that read-bank entry and advance the index; the next entry is presented the following cycle with no bubble.
REQ-030 acc_out, acc_out_last SHALL stay stable while acc_out_valid is high and acc_out_ready is low.
REQ-031 acc_out_last SHALL be high only together with acc_out_valid on entry N_TILES-1.
REQ-032 valid_ctrl[6] during DRAIN SHALL be ignored.
REQ-033 busy SHALL equal (state==DRAIN) | swap_pending, registered.
REQ-034 ovf and err SHALL clear only on reset or clear.

Reset
REQ-035 rst_n low SHALL immediately force state=IDLE, bank_sel=0 (A writes), all entries zero, acc_out=0, acc_out_valid=0, acc_out_last=0, busy=0, ovf=0, err=0, swap_pending=0, including mid-drain.

Verification
REQ-036 Accumulate: sel=2, mac_in lanes all 5, valid_ctrl=12'h009 for 3 cycles, swap, drain -> entry 2 = 15 on all lanes, others 0, last on entry 3.
REQ-037 Saturation: ACC_W=24, lane0 preloaded 8388600, add 100 -> lane0 = 8388607, ovf=1.
REQ-038 Backpressure: drain with acc_out_ready low 5 cycles -> acc_out stable, valid held; ready high -> 4 entries in 4 cycles, read bank zero after.
REQ-039 Swap during drain: valid_ctrl[7] at entry 1 -> busy stays 1, bank_sel toggles exactly once, the cycle after last handshake.
REQ-040 Boundaries: sel=5 with valid_ctrl[0] -> no write, err=1; clear+accumulate same cycle -> entry 0, clear drops flags.
REQ-041 Reset mid-drain: rst_n low at entry 2 -> valid=0, busy=0, all entries zero immediately.
